// File: rtl/alu_control_md.sv
// alu_control_md: RV32I ALU control decode plus iterative M-extension multiply/divide unit
module alu_control_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            start,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic [3:0]      ALUCtrl,
    output logic            md_sel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t state, nxt;
    logic [2*XLEN-1:0] acc, mul_nxt, div_nxt, prod;
    logic [XLEN-1:0]   m, a_abs, b_abs, special_res, fix_res, q, r, diff;
    logic [XLEN:0]     sum;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic              sa, sb, sa_in, sb_in, sa_en, sb_en, div_zero, ovf, special, accept, last, ge;
    assign md_sel = ALUOp == 2'b10 && func7 == 7'b0000001;
    always_comb begin
        ALUCtrl = 4'b0010;
        if (ALUOp == 2'b01)
            case (func3)
                3'b001:  ALUCtrl = 4'b1101;
                3'b100:  ALUCtrl = 4'b1110;
                3'b101:  ALUCtrl = 4'b1111;
                3'b110:  ALUCtrl = 4'b0101;
                3'b111:  ALUCtrl = 4'b0111;
                default: ALUCtrl = 4'b1100;
            endcase
        else if (ALUOp[1] && !md_sel)
            case (func3)
                3'b000:  ALUCtrl = (ALUOp == 2'b10 && func7 == 7'b0100000) ? 4'b0110 : 4'b0010;
                3'b001:  ALUCtrl = 4'b1000;
                3'b010:  ALUCtrl = 4'b0100;
                3'b011:  ALUCtrl = 4'b0011;
                3'b100:  ALUCtrl = 4'b1001;
                3'b101:  ALUCtrl = func7 == 7'b0100000 ? 4'b1011 : 4'b1010;
                3'b110:  ALUCtrl = 4'b0001;
                default: ALUCtrl = 4'b0000;
            endcase
    end
    // opA is signed for MULH, MULHSU, DIV, REM; opB for MULH, DIV, REM
    assign sa_en = func3 == 3'b001 || func3 == 3'b010 || (func3[2] && !func3[0]);
    assign sb_en = func3 == 3'b001 || (func3[2] && !func3[0]);
    assign sa_in = sa_en && opA[XLEN-1];
    assign sb_in = sb_en && opB[XLEN-1];
    assign a_abs = sa_in ? -opA : opA;
    assign b_abs = sb_in ? -opB : opB;
    assign div_zero = func3[2] && opB == '0;
    assign ovf = func3[2] && !func3[0] && opA == {1'b1, {(XLEN-1){1'b0}}} && opB == '1;
    assign special = div_zero || ovf;
    assign special_res = div_zero ? (func3[1] ? opA : '1) : (func3[1] ? '0 : opA);
    assign accept = state == IDLE && start && md_sel;
    assign last = cnt == CW'(XLEN-1);
    assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    assign mul_nxt = {sum, acc[XLEN-1:1]};
    // restoring step: partial remainder holds below the divisor, so the low XLEN bits of the difference suffice
    assign ge = acc[2*XLEN-1:XLEN-1] >= {1'b0, m};
    assign diff = acc[2*XLEN-2:XLEN-1] - m;
    assign div_nxt = ge ? {diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    assign prod = (sa ^ sb) ? -acc : acc;
    assign q = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign r = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = f3[2] ? (f3[1] ? r : q) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = special ? DONE : (func3[2] ? DIV : MUL);
            MUL:     if (last) nxt = FIX;
            DIV:     if (last) nxt = FIX;
            FIX:     nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy = state == MUL || state == DIV || state == FIX;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            m <= '0;
            cnt <= '0;
            f3 <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            md_result <= '0;
        end else begin
            if (accept) begin
                f3 <= func3;
                sa <= sa_in;
                sb <= sb_in;
                cnt <= '0;
                m <= func3[2] ? b_abs : a_abs;
                acc <= {{XLEN{1'b0}}, func3[2] ? a_abs : b_abs};
                if (special) md_result <= special_res;
            end
            if (state == MUL || state == DIV) begin
                acc <= state == MUL ? mul_nxt : div_nxt;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) md_result <= fix_res;
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: scoreboard bench for decode, multiply/divide results, latency and robustness
module tb_alu_control_md;
    localparam int XLEN = 32;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      ALUOp = 2'b00;
    logic [2:0]      func3 = 3'b000;
    logic [6:0]      func7 = 7'b0;
    logic            start = 1'b0;
    logic [XLEN-1:0] opA = '0, opB = '0;
    logic [3:0]      ALUCtrl;
    logic            md_sel, busy, done;
    logic [XLEN-1:0] md_result;
    int tests = 0, fails = 0;
    logic [XLEN-1:0] exp_q[$];

    alu_control_md #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .func3(func3), .func7(func7), .start(start),
        .opA(opA), .opB(opB), .ALUCtrl(ALUCtrl), .md_sel(md_sel), .busy(busy), .done(done),
        .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, b,
                          output logic [XLEN-1:0] res, output int lat, output int bc);
        @(negedge clk);
        ALUOp = 2'b10; func7 = 7'b0000001; func3 = f3; opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bc = 0;
        while (!done && lat < 60) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
        res = md_result;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || md_result !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b md_result=%h, need 0/0/0", busy, done, md_result);
        end
        rst = 1'b0;
    endtask

    task automatic test_decode;
        logic [1:0] ops[8] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01};
        logic [2:0] f3s[8] = '{3'b000, 3'b000, 3'b101, 3'b110, 3'b000, 3'b111, 3'b101, 3'b010};
        logic [6:0] f7s[8] = '{7'h20, 7'h20, 7'h20, 7'h00, 7'h01, 7'h00, 7'h00, 7'h00};
        logic [3:0] ec[8]  = '{4'b0110, 4'b0010, 4'b1011, 4'b0101, 4'b0010, 4'b0010, 4'b1010, 4'b1100};
        logic       es[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ALUOp = ops[i]; func3 = f3s[i]; func7 = f7s[i];
            #1;
            tests++;
            if (ALUCtrl !== ec[i] || md_sel !== es[i]) begin
                fails++;
                $display("FAIL decode[%0d]: ALUCtrl=%b md_sel=%b, need %b/%b", i, ALUCtrl, md_sel, ec[i], es[i]);
            end
        end
    endtask

    task automatic test_mul;
        logic [XLEN-1:0] got, e;
        int lat, bc;
        exp_q.push_back(32'hFFFFFFEB);
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, got, lat, bc);
        e = exp_q.pop_front();
        tests++;
        if (got !== e || lat != 34 || bc != 33) begin
            fails++;
            $display("FAIL mul: result=%h lat=%0d busy=%0d, need %h/34/33", got, lat, bc, e);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || md_result !== e) begin
            fails++;
            $display("FAIL mul_hold: done=%b busy=%b md_result=%h, need 0/0/%h", done, busy, md_result, e);
        end
    endtask

    task automatic test_high_products;
        logic [2:0]      f3s[3] = '{3'b001, 3'b011, 3'b010};
        logic [XLEN-1:0] as[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] bs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] es[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [XLEN-1:0] got, e;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(es[i]);
            run_op(f3s[i], as[i], bs[i], got, lat, bc);
            e = exp_q.pop_front();
            tests++;
            if (got !== e || lat != 34 || bc != 33) begin
                fails++;
                $display("FAIL mulhi[%0d]: result=%h lat=%0d busy=%0d, need %h/34/33", i, got, lat, bc, e);
            end
        end
    endtask

    task automatic test_divide;
        logic [2:0]      f3s[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [XLEN-1:0] as[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [XLEN-1:0] bs[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [XLEN-1:0] es[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [XLEN-1:0] got, e;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(es[i]);
            run_op(f3s[i], as[i], bs[i], got, lat, bc);
            e = exp_q.pop_front();
            tests++;
            if (got !== e || lat != 34 || bc != 33) begin
                fails++;
                $display("FAIL div[%0d]: result=%h lat=%0d busy=%0d, need %h/34/33", i, got, lat, bc, e);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]      f3s[4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [XLEN-1:0] as[4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [XLEN-1:0] bs[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] es[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [XLEN-1:0] got, e;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(es[i]);
            run_op(f3s[i], as[i], bs[i], got, lat, bc);
            e = exp_q.pop_front();
            tests++;
            if (got !== e || lat != 1 || bc != 0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL special[%0d]: result=%h lat=%0d busy=%0d, need %h/1/0", i, got, lat, bc, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [XLEN-1:0] got, e;
        int lat, bc;
        exp_q.push_back(32'd42);
        run_op(3'b000, 32'd6, 32'd7, got, lat, bc);
        exp_q.push_back(32'd20);
        run_op(3'b000, 32'd4, 32'd5, got, lat, bc);
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        tests++;
        if (got !== e || lat != 34) begin
            fails++;
            $display("FAIL back_to_back: result=%h lat=%0d, need %h/34", got, lat, e);
        end
    endtask

    task automatic test_ignore_start;
        logic [XLEN-1:0] e;
        int lat;
        exp_q.push_back(32'd143);
        @(negedge clk);
        ALUOp = 2'b10; func7 = 7'b0000001; func3 = 3'b000; opA = 32'd11; opB = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 5) begin
                func3 = 3'b101; opA = 32'd99; opB = 32'd3; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (md_result !== e || lat != 34) begin
            fails++;
            $display("FAIL ignore_start: result=%h lat=%0d, need %h/34", md_result, lat, e);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, need 0/0", busy, done);
        end
    endtask

    task automatic test_reset_abort;
        logic [XLEN-1:0] got, e;
        int lat, bc, pulses;
        @(negedge clk);
        ALUOp = 2'b10; func7 = 7'b0000001; func3 = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || md_result !== '0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: busy=%b done=%b md_result=%h, need 0/0/0", busy, done, md_result);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            pulses += int'(done);
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_abort_done: %0d done pulses, need 0", pulses);
        end
        exp_q.push_back(32'd14);
        run_op(3'b101, 32'd100, 32'd7, got, lat, bc);
        e = exp_q.pop_front();
        tests++;
        if (got !== e || lat != 34) begin
            fails++;
            $display("FAIL reset_restart: result=%h lat=%0d, need %h/34", got, lat, e);
        end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_mul;
        test_high_products;
        test_divide;
        test_special;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
